// File: rtl/reservation_station_pkg.sv
// Shared defines for the integer issue path: data/tag types, opcode encodings
// and the reservation-station entry layout.
package reservation_station_pkg;

  localparam int unsigned RS_SIZE        = 16;
  localparam int unsigned RS_INDEX_WIDTH = 4;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef logic [31:0]               DATA_TYPE;
  typedef logic [31:0]               ADDR_TYPE;
  typedef logic [3:0]                ROB_INDEX_TYPE;
  typedef logic [RS_INDEX_WIDTH-1:0] RS_INDEX_TYPE;

  typedef enum logic [4:0] {
    OPENUM_NOP   = 5'd0,
    OPENUM_LUI   = 5'd1,
    OPENUM_AUIPC = 5'd2,
    OPENUM_JAL   = 5'd3,
    OPENUM_JALR  = 5'd4,
    OPENUM_BEQ   = 5'd5,
    OPENUM_BNE   = 5'd6,
    OPENUM_BLT   = 5'd7,
    OPENUM_BGE   = 5'd8,
    OPENUM_BLTU  = 5'd9,
    OPENUM_BGEU  = 5'd10,
    OPENUM_ADD   = 5'd11,
    OPENUM_SUB   = 5'd12,
    OPENUM_AND   = 5'd13,
    OPENUM_OR    = 5'd14,
    OPENUM_XOR   = 5'd15,
    OPENUM_SLL   = 5'd16,
    OPENUM_SRL   = 5'd17,
    OPENUM_SRA   = 5'd18,
    OPENUM_SLT   = 5'd19,
    OPENUM_SLTU  = 5'd20
  } OPENUM_TYPE;

  typedef struct packed {
    OPENUM_TYPE    op;
    DATA_TYPE      vj;
    DATA_TYPE      vk;
    ROB_INDEX_TYPE qj;
    ROB_INDEX_TYPE qk;
    logic          pend_j;
    logic          pend_k;
    DATA_TYPE      imm;
    ADDR_TYPE      pc;
    ROB_INDEX_TYPE rob;
  } rs_entry_t;

  typedef struct packed {
    logic     hit;
    DATA_TYPE val;
  } snoop_t;

  // ALU bus is checked first so it wins if both buses carry the same tag.
  function automatic snoop_t snoop(input ROB_INDEX_TYPE tag,
                                   input logic a_rdy, input ROB_INDEX_TYPE a_tag, input DATA_TYPE a_val,
                                   input logic l_rdy, input ROB_INDEX_TYPE l_tag, input DATA_TYPE l_val);
    snoop_t s;
    s.hit = FALSE;
    s.val = '0;
    if (a_rdy && a_tag == tag) begin
      s.hit = TRUE;
      s.val = a_val;
    end else if (l_rdy && l_tag == tag) begin
      s.hit = TRUE;
      s.val = l_val;
    end
    return s;
  endfunction

endpackage

// File: rtl/reservation_station_priority_enc.sv
// Lowest-set-bit encoder with a valid flag.
module rs_priority_enc #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned IDX_W = 4
) (
  input  logic [WIDTH-1:0] req_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int unsigned i = WIDTH; i > 0; i--) begin
      if (req_i[i-1]) begin
        idx_o   = IDX_W'(i - 1);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Reservation station: buffers dispatched ALU/branch ops, snoops the ALU and
// LSB result buses and issues the lowest-index ready entry each cycle.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int unsigned RS_SIZE        = reservation_station_pkg::RS_SIZE,
  parameter int unsigned RS_INDEX_WIDTH = reservation_station_pkg::RS_INDEX_WIDTH
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  input  logic          clr_in,
  input  logic          dispatch_valid,
  input  OPENUM_TYPE    dispatch_op,
  input  DATA_TYPE      dispatch_rs1_val,
  input  DATA_TYPE      dispatch_rs2_val,
  input  logic          dispatch_rs1_pend,
  input  logic          dispatch_rs2_pend,
  input  ROB_INDEX_TYPE dispatch_rs1_rob,
  input  ROB_INDEX_TYPE dispatch_rs2_rob,
  input  DATA_TYPE      dispatch_imm,
  input  ADDR_TYPE      dispatch_PC,
  input  ROB_INDEX_TYPE dispatch_rob_index,
  output logic          rs_full,
  input  logic          alu_ready,
  input  DATA_TYPE      alu_result,
  input  ROB_INDEX_TYPE alu_rob_index,
  input  logic          lsb_ready,
  input  DATA_TYPE      lsb_result,
  input  ROB_INDEX_TYPE lsb_rob_index,
  output logic          rs_to_alu_ready,
  output OPENUM_TYPE    rs_to_alu_op,
  output DATA_TYPE      rs_to_alu_rs1,
  output DATA_TYPE      rs_to_alu_rs2,
  output DATA_TYPE      rs_to_alu_imm,
  output ADDR_TYPE      rs_to_alu_PC,
  output ROB_INDEX_TYPE rs_to_alu_rob_index
);

  logic [RS_SIZE-1:0]        busy_q, busy_d;
  rs_entry_t                 ent_q [RS_SIZE];
  rs_entry_t                 ent_d [RS_SIZE];
  logic [RS_SIZE-1:0]        ready_mask;
  logic [RS_INDEX_WIDTH-1:0] free_idx, iss_idx;
  logic                      free_valid, iss_valid;
  rs_entry_t                 new_ent;
  snoop_t                    s_j, s_k, d_j, d_k;

  rs_priority_enc #(.WIDTH(RS_SIZE), .IDX_W(RS_INDEX_WIDTH)) u_free_enc (
    .req_i   (~busy_q),
    .idx_o   (free_idx),
    .valid_o (free_valid)
  );

  rs_priority_enc #(.WIDTH(RS_SIZE), .IDX_W(RS_INDEX_WIDTH)) u_ready_enc (
    .req_i   (ready_mask),
    .idx_o   (iss_idx),
    .valid_o (iss_valid)
  );

  assign rs_full = ~free_valid;

  always_comb begin
    ready_mask = '0;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      ready_mask[i] = busy_q[i] & ~ent_q[i].pend_j & ~ent_q[i].pend_k;
    end
  end

  always_comb begin
    d_j = snoop(dispatch_rs1_rob, alu_ready, alu_rob_index, alu_result,
                lsb_ready, lsb_rob_index, lsb_result);
    d_k = snoop(dispatch_rs2_rob, alu_ready, alu_rob_index, alu_result,
                lsb_ready, lsb_rob_index, lsb_result);
    new_ent.op     = dispatch_op;
    new_ent.qj     = dispatch_rs1_rob;
    new_ent.qk     = dispatch_rs2_rob;
    new_ent.pend_j = dispatch_rs1_pend & ~d_j.hit;
    new_ent.pend_k = dispatch_rs2_pend & ~d_k.hit;
    new_ent.vj     = (dispatch_rs1_pend && d_j.hit) ? d_j.val : dispatch_rs1_val;
    new_ent.vk     = (dispatch_rs2_pend && d_k.hit) ? d_k.val : dispatch_rs2_val;
    new_ent.imm    = dispatch_imm;
    new_ent.pc     = dispatch_PC;
    new_ent.rob    = dispatch_rob_index;
  end

  // The issued entry is busy, so it can never be the dispatch target.
  always_comb begin
    busy_d = busy_q;
    s_j    = '0;
    s_k    = '0;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      ent_d[i] = ent_q[i];
      s_j = snoop(ent_q[i].qj, alu_ready, alu_rob_index, alu_result,
                  lsb_ready, lsb_rob_index, lsb_result);
      s_k = snoop(ent_q[i].qk, alu_ready, alu_rob_index, alu_result,
                  lsb_ready, lsb_rob_index, lsb_result);
      if (busy_q[i] && ent_q[i].pend_j && s_j.hit) begin
        ent_d[i].vj     = s_j.val;
        ent_d[i].pend_j = 1'b0;
      end
      if (busy_q[i] && ent_q[i].pend_k && s_k.hit) begin
        ent_d[i].vk     = s_k.val;
        ent_d[i].pend_k = 1'b0;
      end
    end
    if (iss_valid) busy_d[iss_idx] = 1'b0;
    if (dispatch_valid && free_valid) begin
      busy_d[free_idx] = 1'b1;
      ent_d[free_idx]  = new_ent;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy_q              <= '0;
      ent_q               <= '{default: '0};
      rs_to_alu_ready     <= 1'b0;
      rs_to_alu_op        <= OPENUM_NOP;
      rs_to_alu_rs1       <= '0;
      rs_to_alu_rs2       <= '0;
      rs_to_alu_imm       <= '0;
      rs_to_alu_PC        <= '0;
      rs_to_alu_rob_index <= '0;
    end else if (clr_in) begin
      busy_q          <= '0;
      rs_to_alu_ready <= 1'b0;
    end else if (rdy_in) begin
      busy_q          <= busy_d;
      ent_q           <= ent_d;
      rs_to_alu_ready <= iss_valid;
      if (iss_valid) begin
        rs_to_alu_op        <= ent_q[iss_idx].op;
        rs_to_alu_rs1       <= ent_q[iss_idx].vj;
        rs_to_alu_rs2       <= ent_q[iss_idx].vk;
        rs_to_alu_imm       <= ent_q[iss_idx].imm;
        rs_to_alu_PC        <= ent_q[iss_idx].pc;
        rs_to_alu_rob_index <= ent_q[iss_idx].rob;
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Directed-vector bench for reservation_station with hand-computed expectations.
module tb_reservation_station;
  import reservation_station_pkg::*;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          rdy_in;
  logic          clr_in;
  logic          dispatch_valid;
  OPENUM_TYPE    dispatch_op;
  DATA_TYPE      dispatch_rs1_val, dispatch_rs2_val;
  logic          dispatch_rs1_pend, dispatch_rs2_pend;
  ROB_INDEX_TYPE dispatch_rs1_rob, dispatch_rs2_rob;
  DATA_TYPE      dispatch_imm;
  ADDR_TYPE      dispatch_PC;
  ROB_INDEX_TYPE dispatch_rob_index;
  logic          rs_full;
  logic          alu_ready, lsb_ready;
  DATA_TYPE      alu_result, lsb_result;
  ROB_INDEX_TYPE alu_rob_index, lsb_rob_index;
  logic          rs_to_alu_ready;
  OPENUM_TYPE    rs_to_alu_op;
  DATA_TYPE      rs_to_alu_rs1, rs_to_alu_rs2, rs_to_alu_imm;
  ADDR_TYPE      rs_to_alu_PC;
  ROB_INDEX_TYPE rs_to_alu_rob_index;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk_in = ~clk_in;

  reservation_station #(.RS_SIZE(16), .RS_INDEX_WIDTH(4)) dut (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .rdy_in              (rdy_in),
    .clr_in              (clr_in),
    .dispatch_valid      (dispatch_valid),
    .dispatch_op         (dispatch_op),
    .dispatch_rs1_val    (dispatch_rs1_val),
    .dispatch_rs2_val    (dispatch_rs2_val),
    .dispatch_rs1_pend   (dispatch_rs1_pend),
    .dispatch_rs2_pend   (dispatch_rs2_pend),
    .dispatch_rs1_rob    (dispatch_rs1_rob),
    .dispatch_rs2_rob    (dispatch_rs2_rob),
    .dispatch_imm        (dispatch_imm),
    .dispatch_PC         (dispatch_PC),
    .dispatch_rob_index  (dispatch_rob_index),
    .rs_full             (rs_full),
    .alu_ready           (alu_ready),
    .alu_result          (alu_result),
    .alu_rob_index       (alu_rob_index),
    .lsb_ready           (lsb_ready),
    .lsb_result          (lsb_result),
    .lsb_rob_index       (lsb_rob_index),
    .rs_to_alu_ready     (rs_to_alu_ready),
    .rs_to_alu_op        (rs_to_alu_op),
    .rs_to_alu_rs1       (rs_to_alu_rs1),
    .rs_to_alu_rs2       (rs_to_alu_rs2),
    .rs_to_alu_imm       (rs_to_alu_imm),
    .rs_to_alu_PC        (rs_to_alu_PC),
    .rs_to_alu_rob_index (rs_to_alu_rob_index)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic disp(input OPENUM_TYPE op,
                      input DATA_TYPE v1, input logic p1, input ROB_INDEX_TYPE q1,
                      input DATA_TYPE v2, input logic p2, input ROB_INDEX_TYPE q2,
                      input ROB_INDEX_TYPE rob);
    dispatch_valid     = 1'b1;
    dispatch_op        = op;
    dispatch_rs1_val   = v1;
    dispatch_rs1_pend  = p1;
    dispatch_rs1_rob   = q1;
    dispatch_rs2_val   = v2;
    dispatch_rs2_pend  = p2;
    dispatch_rs2_rob   = q2;
    dispatch_rob_index = rob;
    dispatch_imm       = 32'h100 + 32'(rob);
    dispatch_PC        = 32'h1000 + 32'(rob) * 4;
  endtask

  task automatic nodisp();
    dispatch_valid    = 1'b0;
    dispatch_rs1_pend = 1'b0;
    dispatch_rs2_pend = 1'b0;
  endtask

  task automatic alu_bcast(input logic en, input ROB_INDEX_TYPE tag, input DATA_TYPE val);
    alu_ready     = en;
    alu_rob_index = tag;
    alu_result    = val;
  endtask

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; clr_in = 1'b0;
    dispatch_op = OPENUM_NOP; dispatch_rs1_val = '0; dispatch_rs2_val = '0;
    dispatch_rs1_rob = '0; dispatch_rs2_rob = '0; dispatch_imm = '0;
    dispatch_PC = '0; dispatch_rob_index = '0;
    nodisp();
    alu_bcast(1'b0, 4'd0, 32'h0);
    lsb_ready = 1'b0; lsb_rob_index = '0; lsb_result = '0;
    step(); step();
    rst_in = 1'b1;
    step();
    check_eq("rst_ready", 64'(rs_to_alu_ready), 64'd0);
    check_eq("rst_full",  64'(rs_full), 64'd0);
    check_eq("rst_rs1",   64'(rs_to_alu_rs1), 64'd0);
    check_eq("rst_op",    64'(rs_to_alu_op), 64'(OPENUM_NOP));

    // ADD, both operands ready: issue two edges after dispatch
    disp(OPENUM_ADD, 32'd5, 1'b0, 4'd0, 32'd7, 1'b0, 4'd0, 4'd3);
    step(); nodisp();
    check_eq("add_not_yet", 64'(rs_to_alu_ready), 64'd0);
    step();
    check_eq("add_ready", 64'(rs_to_alu_ready), 64'd1);
    check_eq("add_op",    64'(rs_to_alu_op), 64'(OPENUM_ADD));
    check_eq("add_rs1",   64'(rs_to_alu_rs1), 64'd5);
    check_eq("add_rs2",   64'(rs_to_alu_rs2), 64'd7);
    check_eq("add_rob",   64'(rs_to_alu_rob_index), 64'd3);
    check_eq("add_imm",   64'(rs_to_alu_imm), 64'h103);
    check_eq("add_pc",    64'(rs_to_alu_PC), 64'h100C);
    step();
    check_eq("add_strobe_low", 64'(rs_to_alu_ready), 64'd0);
    check_eq("add_hold_rs1",   64'(rs_to_alu_rs1), 64'd5);

    // SUB waiting on ROB 2, woken by the ALU bus
    disp(OPENUM_SUB, 32'd0, 1'b1, 4'd2, 32'd1, 1'b0, 4'd0, 4'd4);
    step(); nodisp();
    step();
    check_eq("sub_wait", 64'(rs_to_alu_ready), 64'd0);
    alu_bcast(1'b1, 4'd2, 32'h10);
    step();
    alu_bcast(1'b0, 4'd0, 32'h0);
    check_eq("sub_wake_edge", 64'(rs_to_alu_ready), 64'd0);
    step();
    check_eq("sub_ready", 64'(rs_to_alu_ready), 64'd1);
    check_eq("sub_rs1",   64'(rs_to_alu_rs1), 64'h10);
    check_eq("sub_rs2",   64'(rs_to_alu_rs2), 64'd1);
    check_eq("sub_rob",   64'(rs_to_alu_rob_index), 64'd4);

    // Dispatch bypass from the LSB bus in the dispatch cycle
    disp(OPENUM_XOR, 32'd0, 1'b1, 4'd6, 32'd2, 1'b0, 4'd0, 4'd5);
    lsb_ready = 1'b1; lsb_rob_index = 4'd6; lsb_result = 32'hABC;
    step(); nodisp();
    lsb_ready = 1'b0;
    check_eq("byp_not_yet", 64'(rs_to_alu_ready), 64'd0);
    step();
    check_eq("byp_ready", 64'(rs_to_alu_ready), 64'd1);
    check_eq("byp_rs1",   64'(rs_to_alu_rs1), 64'hABC);
    check_eq("byp_rob",   64'(rs_to_alu_rob_index), 64'd5);
    step();

    // Fill all 16 entries pending on ROB 9; 17th dispatch is dropped
    for (int i = 0; i < 16; i++) begin
      disp(OPENUM_OR, 32'd0, 1'b1, 4'd9, 32'(i), 1'b0, 4'd0, 4'(i));
      step();
    end
    check_eq("fill_full", 64'(rs_full), 64'd1);
    disp(OPENUM_OR, 32'd0, 1'b0, 4'd0, 32'h77, 1'b0, 4'd0, 4'd0);
    step(); nodisp();
    check_eq("drop_full",  64'(rs_full), 64'd1);
    check_eq("drop_ready", 64'(rs_to_alu_ready), 64'd0);
    alu_bcast(1'b1, 4'd9, 32'h900);
    step();
    alu_bcast(1'b0, 4'd0, 32'h0);
    for (int i = 0; i < 16; i++) begin
      step();
      check_eq($sformatf("drain_ready_%0d", i), 64'(rs_to_alu_ready), 64'd1);
      check_eq($sformatf("drain_rs2_%0d", i),   64'(rs_to_alu_rs2), 64'(i));
      check_eq($sformatf("drain_rs1_%0d", i),   64'(rs_to_alu_rs1), 64'h900);
    end
    step();
    check_eq("drain_done",  64'(rs_to_alu_ready), 64'd0);
    check_eq("drain_empty", 64'(rs_full), 64'd0);

    // Flush a full station while entry 15 is about to issue
    for (int i = 0; i < 15; i++) begin
      disp(OPENUM_AND, 32'd0, 1'b1, 4'd1, 32'd0, 1'b0, 4'd0, 4'(i));
      step();
    end
    disp(OPENUM_AND, 32'h55, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd15);
    step(); nodisp();
    check_eq("clr_pre_full", 64'(rs_full), 64'd1);
    clr_in = 1'b1;
    step();
    clr_in = 1'b0;
    check_eq("clr_ready", 64'(rs_to_alu_ready), 64'd0);
    check_eq("clr_full",  64'(rs_full), 64'd0);
    alu_bcast(1'b1, 4'd1, 32'h11);
    step();
    alu_bcast(1'b0, 4'd0, 32'h0);
    check_eq("clr_after1", 64'(rs_to_alu_ready), 64'd0);
    step();
    check_eq("clr_after2", 64'(rs_to_alu_ready), 64'd0);

    // rdy_in low freezes issue, wakeup and dispatch
    disp(OPENUM_SLT, 32'd0, 1'b1, 4'd8, 32'd0, 1'b0, 4'd0, 4'd11);
    step();
    disp(OPENUM_SLL, 32'h33, 1'b0, 4'd0, 32'h44, 1'b0, 4'd0, 4'd7);
    step();
    rdy_in = 1'b0;
    disp(OPENUM_SRL, 32'hCC, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd12);
    alu_bcast(1'b1, 4'd8, 32'h88);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq($sformatf("frz_ready_%0d", i), 64'(rs_to_alu_ready), 64'd0);
    end
    rdy_in = 1'b1;
    nodisp();
    alu_bcast(1'b0, 4'd0, 32'h0);
    step();
    check_eq("frz_resume_ready", 64'(rs_to_alu_ready), 64'd1);
    check_eq("frz_resume_rs1",   64'(rs_to_alu_rs1), 64'h33);
    check_eq("frz_resume_rob",   64'(rs_to_alu_rob_index), 64'd7);
    step();
    check_eq("frz_no_wake", 64'(rs_to_alu_ready), 64'd0);
    alu_bcast(1'b1, 4'd8, 32'h88);
    step();
    alu_bcast(1'b0, 4'd0, 32'h0);
    step();
    check_eq("frz_late_ready", 64'(rs_to_alu_ready), 64'd1);
    check_eq("frz_late_rs1",   64'(rs_to_alu_rs1), 64'h88);
    check_eq("frz_late_rob",   64'(rs_to_alu_rob_index), 64'd11);
    step();
    check_eq("frz_drop", 64'(rs_to_alu_ready), 64'd0);

    // Reset mid-operation discards a ready entry
    disp(OPENUM_ADD, 32'h1, 1'b0, 4'd0, 32'h2, 1'b0, 4'd0, 4'd6);
    step(); nodisp();
    #2 rst_in = 1'b0;
    #1;
    check_eq("mid_rst_ready", 64'(rs_to_alu_ready), 64'd0);
    check_eq("mid_rst_rs1",   64'(rs_to_alu_rs1), 64'd0);
    step();
    rst_in = 1'b1;
    step();
    check_eq("mid_rst_no_issue", 64'(rs_to_alu_ready), 64'd0);
    check_eq("mid_rst_full",     64'(rs_full), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reservation_station.md
# reservation_station

Issue-side reservation station for the out-of-order integer pipeline. It buffers decoded ALU and branch instructions from the dispatcher and captures operand values broadcast by the ALU and LSB result buses. It selects one ready entry per cycle and drives the `rs_to_alu_*` issue interface consumed by the ALU. It is the producer end of the RS→ALU interface.

## Interface
- `RS_SIZE`, 16: number of entries, power of two.
- `RS_INDEX_WIDTH`, 4: log2(`RS_SIZE`).
- `clk_in`  in  1  clock; all state changes on the rising edge.
- `rst_in`  in  1  asynchronous, active-low reset.
- `rdy_in`  in  1  global enable; low freezes all state.
- `clr_in`  in  1  synchronous flush on branch mispredict.
- `dispatch_valid`  in  1  new instruction this cycle.
- `dispatch_op`  in  `OPENUM_TYPE`  opcode enum.
- `dispatch_rs1_val`, `dispatch_rs2_val`  in  `DATA_TYPE`  operand values, valid when the matching `_pend` is low.
- `dispatch_rs1_pend`, `dispatch_rs2_pend`  in  1  operand still awaits a ROB result.
- `dispatch_rs1_rob`, `dispatch_rs2_rob`  in  `ROB_INDEX_TYPE`  producing ROB tag.
- `dispatch_imm`  in  `DATA_TYPE`  immediate.
- `dispatch_PC`  in  `ADDR_TYPE`  instruction PC.
- `dispatch_rob_index`  in  `ROB_INDEX_TYPE`  destination ROB entry.
- `rs_full`  out  1  no free entry (combinational from registered busy vector).
- `alu_ready`, `alu_result`, `alu_rob_index`  in  1/`DATA_TYPE`/`ROB_INDEX_TYPE`  ALU broadcast.
- `lsb_ready`, `lsb_result`, `lsb_rob_index`  in  1/`DATA_TYPE`/`ROB_INDEX_TYPE`  LSB broadcast.
- `rs_to_alu_ready`  out  1  registered one-cycle issue strobe.
- `rs_to_alu_op`, `rs_to_alu_rs1`, `rs_to_alu_rs2`, `rs_to_alu_imm`, `rs_to_alu_PC`, `rs_to_alu_rob_index`  out  registered issue payload.

## Operation
- Each entry holds busy, op, Vj, Vk, Qj, Qk, pend_j, pend_k, imm, PC, and rob_index.
- Dispatch: when `dispatch_valid` is high and `rs_full` is low, write the lowest-index free entry and set busy. Dispatch while full is dropped.
- Dispatch bypass: if a dispatched operand is pending and its tag matches an active broadcast in the same cycle, store the broadcast value and clear its pend bit.
- Wakeup: for every busy entry, a pending operand whose Q matches `alu_rob_index` while `alu_ready` is high, or `lsb_rob_index` while `lsb_ready` is high, latches the value and clears its pend bit. Vj and Vk are checked independently, so a shared tag wakes both.
- Both buses carrying the same tag is illegal. If it occurs, the ALU bus wins.
- Select: the lowest-index entry with busy set and both pend bits clear, evaluated on registered state only. On the next edge:
  - drive the payload,
  - set `rs_to_alu_ready` high,
  - clear that entry's busy bit.
- With no candidate, `rs_to_alu_ready` goes low and the payload holds its last value.
- The freed slot becomes visible to `rs_full` one cycle after issue.
- `clr_in` high: clear every busy bit and drive `rs_to_alu_ready` low. Flush has priority over dispatch, wakeup and issue in that cycle.
- `rdy_in` low, with `clr_in` and `rst_in` inactive: hold every register. Broadcasts and dispatch in that cycle are ignored.
- Reset: all busy bits 0 and all outputs 0 (`rs_to_alu_ready` is 0). Reset can occur mid-operation and discards every entry.

## Timing
- Dispatch with both operands ready at edge N: entry busy after N. It is selectable in cycle N+1, and `rs_to_alu_ready` is high after edge N+1. Minimum latency is 2 cycles.
- Broadcast in cycle N wakes the entry after N, and the entry issues after N+1.
- An entry dispatched in cycle N is never issued from edge N.
- Throughput is one issue per cycle. Dispatch and issue are allowed in the same cycle.
- Priority at each edge: reset (async), then `clr_in`, then `rdy_in`, then normal operation.

## Structure
- The shared defines package holds:
  - `OPENUM_TYPE`, `DATA_TYPE`, `ADDR_TYPE`, `ROB_INDEX_TYPE`, and the `OPENUM_*` encodings;
  - `RS_SIZE` and `RS_INDEX_TYPE`;
  - `TRUE` and `FALSE`.
- Sub-module `rs_priority_enc`: lowest-set-bit encoder with valid output. Instantiate it twice, once for the free mask (~busy) and once for the ready mask (busy & ~pend_j & ~pend_k).

## Test plan
- Reset, then dispatch ADD (rs1=5, rs2=7, both ready, rob 3): after 2 edges `rs_to_alu_ready`=1, rs1=5, rs2=7, rob_index=3; the strobe is low on the following cycle.
- Dispatch SUB with rs1 pending on rob 2 and rs2=1 ready; two cycles later `alu_ready`=1, `alu_rob_index`=2, `alu_result`=0x10 → issue with rs1=0x10, rs2=1 one edge after the broadcast edge.
- Dispatch an instruction with rs1 pending on rob 6 while `lsb_ready`=1 and `lsb_rob_index`=6 in the same cycle → rs1 holds the LSB value and the instruction issues 2 edges later.
- Fill all 16 entries with operands pending on rob 9 → `rs_full`=1 and a 17th dispatch is dropped. A broadcast of rob 9 → entries issue in index order 0..15 over 16 consecutive cycles.
- Four entries busy, assert `clr_in` → `rs_to_alu_ready`=0 and `rs_full`=0 next cycle, and no further issues occur.
- Hold `rdy_in` low for 3 cycles while a ready entry exists and `alu_ready` pulses → no issue and no wakeup occur; normal issue resumes on the first edge with `rdy_in` high.
